vram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for a single-port, synchronous-read video/character RAM (1-cycle read latency, write on `ce & we`). Shares the RAM between the video fetch engine (strict priority) and the Z80 bus, and stretches CPU cycles with `cpu_wait_n` until the access completes. A saturating starvation counter bounds CPU latency. Sits between the Z80 memory decoder, the video generator and one RAM instance.

---
 rtl/vram_arb_defs_pkg.sv | 22 ++
 rtl/vram_arbiter_starve_ctr.sv | 44 ++++
 rtl/vram_arbiter.sv | 139 +++++++++++++
 tb/tb_vram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_defs_pkg.sv
// Shared encodings for the VRAM arbiter: RAM slot owner, CPU sequencer states
// and the default RAM geometry.
package vram_arb_defs;

   localparam int DEF_AW = 10;
   localparam int DEF_DW = 8;

   typedef enum logic [1:0] {
      SLOT_NONE = 2'd0,
      SLOT_VID  = 2'd1,
      SLOT_CPU  = 2'd2
   } slot_e;

   typedef enum logic [2:0] {
      C_IDLE  = 3'd0,
      C_PEND  = 3'd1,
      C_ISSUE = 3'd2,
      C_DATA  = 3'd3,
      C_DONE  = 3'd4
   } cpu_state_e;

endpackage

// File: rtl/vram_arbiter_starve_ctr.sv
// Saturating count of consecutive denied CPU cycles; sat flags count >= LIMIT.
// LIMIT of 0 disables the flag entirely.
module starve_ctr #(
   parameter int LIMIT = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   generate
      if (LIMIT == 0) begin : g_off
         logic unused_inputs;
         assign unused_inputs = ^{clk, rst_n, inc, clr};
         assign sat = 1'b0;
      end else begin : g_on
         localparam int W = $clog2(LIMIT + 1);
         logic [W-1:0] cnt_q;
         logic [W-1:0] cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (clr) begin
               cnt_d = '0;
            end else if (inc && (cnt_q < W'(LIMIT))) begin
               cnt_d = cnt_q + W'(1);
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign sat = (cnt_q >= W'(LIMIT));
      end
   endgenerate

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch has priority, the Z80 is stretched with
// cpu_wait_n until its access completes, and a starvation limit bounds CPU delay.
module vram_arbiter
   import vram_arb_defs::*;
#(
   parameter int AW           = DEF_AW,
   parameter int DW           = DEF_DW,
   parameter int CPU_MAX_WAIT = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   output logic          vid_valid,
   output logic [DW-1:0] vid_data,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   output logic [DW-1:0] cpu_dout,
   output logic          cpu_wait_n,
   output logic [AW-1:0] ram_a,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   output logic          ram_ce,
   input  logic [DW-1:0] ram_dout
);

   slot_e        slot_q, slot_d;
   cpu_state_e   state_q, state_d;
   logic [AW-1:0] ram_a_q, ram_a_d;
   logic [DW-1:0] ram_din_q, ram_din_d;
   logic          ram_we_q, ram_we_d;
   logic          ram_ce_q, ram_ce_d;
   logic          vid_valid_q, vid_valid_d;
   logic [DW-1:0] cpu_dout_q, cpu_dout_d;

   logic cpu_cand;
   logic cpu_grant;
   logic vid_grant;
   logic starve_sat;

   // A dropped request in C_PEND must not win a slot, so candidacy needs cpu_req.
   assign cpu_cand  = cpu_req && ((state_q == C_IDLE) || (state_q == C_PEND));
   assign cpu_grant = cpu_cand && (!vid_req || starve_sat);
   assign vid_grant = vid_req && !cpu_grant;

   starve_ctr #(
      .LIMIT (CPU_MAX_WAIT)
   ) u_starve (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cpu_cand && !cpu_grant),
      .clr   (!cpu_cand || cpu_grant),
      .sat   (starve_sat)
   );

   always_comb begin
      slot_d      = SLOT_NONE;
      ram_a_d     = ram_a_q;
      ram_din_d   = ram_din_q;
      ram_we_d    = 1'b0;
      state_d     = state_q;
      cpu_dout_d  = cpu_dout_q;
      vid_valid_d = (slot_q == SLOT_VID);

      if (cpu_grant) begin
         slot_d    = SLOT_CPU;
         ram_a_d   = cpu_addr;
         ram_din_d = cpu_din;
         ram_we_d  = cpu_we;
      end else if (vid_grant) begin
         slot_d  = SLOT_VID;
         ram_a_d = vid_addr;
      end
      ram_ce_d = (slot_d != SLOT_NONE);

      case (state_q)
         C_IDLE: begin
            if (cpu_req) begin
               state_d = cpu_grant ? C_ISSUE : C_PEND;
            end
         end
         C_PEND: begin
            if (!cpu_req) begin
               state_d = C_IDLE;
            end else if (cpu_grant) begin
               state_d = C_ISSUE;
            end
         end
         // ram_we_q is only ever set by a CPU write slot, which is the one on the RAM now.
         C_ISSUE: state_d = ram_we_q ? C_DONE : C_DATA;
         C_DATA: begin
            cpu_dout_d = ram_dout;
            state_d    = C_DONE;
         end
         C_DONE: begin
            if (!cpu_req) begin
               state_d = C_IDLE;
            end
         end
         default: state_d = C_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q      <= SLOT_NONE;
         state_q     <= C_IDLE;
         ram_a_q     <= '0;
         ram_din_q   <= '0;
         ram_we_q    <= 1'b0;
         ram_ce_q    <= 1'b0;
         vid_valid_q <= 1'b0;
         cpu_dout_q  <= '0;
      end else begin
         slot_q      <= slot_d;
         state_q     <= state_d;
         ram_a_q     <= ram_a_d;
         ram_din_q   <= ram_din_d;
         ram_we_q    <= ram_we_d;
         ram_ce_q    <= ram_ce_d;
         vid_valid_q <= vid_valid_d;
         cpu_dout_q  <= cpu_dout_d;
      end
   end

   assign vid_ack    = vid_grant && rst_n;
   assign vid_valid  = vid_valid_q;
   assign vid_data   = ram_dout;
   assign cpu_dout   = cpu_dout_q;
   assign cpu_wait_n = !rst_n || !(cpu_req && (state_q != C_DONE));
   assign ram_a      = ram_a_q;
   assign ram_din    = ram_din_q;
   assign ram_we     = ram_we_q;
   assign ram_ce     = ram_ce_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised bench: two arbiters (starvation limit 8 and disabled) share stimulus,
// each with its own RAM; results are compared against latency rules and a memory image.
module tb_vram_arbiter;

   localparam int AW = 10;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vid_req = 1'b0;
   logic [AW-1:0] vid_addr = '0;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_din = '0;

   logic          vid_ack_a, vid_valid_a, cpu_wait_n_a, ram_we_a, ram_ce_a;
   logic [DW-1:0] vid_data_a, cpu_dout_a, ram_din_a;
   logic [AW-1:0] ram_a_a;
   logic [DW-1:0] ram_dout_a = '0;
   logic          vid_ack_b, vid_valid_b, cpu_wait_n_b, ram_we_b, ram_ce_b;
   logic [DW-1:0] vid_data_b, cpu_dout_b, ram_din_b;
   logic [AW-1:0] ram_a_b;
   logic [DW-1:0] ram_dout_b = '0;

   vram_arbiter #(.AW(AW), .DW(DW), .CPU_MAX_WAIT(8)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack_a),
      .vid_valid(vid_valid_a), .vid_data(vid_data_a),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout_a), .cpu_wait_n(cpu_wait_n_a),
      .ram_a(ram_a_a), .ram_din(ram_din_a), .ram_we(ram_we_a), .ram_ce(ram_ce_a),
      .ram_dout(ram_dout_a)
   );

   vram_arbiter #(.AW(AW), .DW(DW), .CPU_MAX_WAIT(0)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack_b),
      .vid_valid(vid_valid_b), .vid_data(vid_data_b),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout_b), .cpu_wait_n(cpu_wait_n_b),
      .ram_a(ram_a_b), .ram_din(ram_din_b), .ram_we(ram_we_b), .ram_ce(ram_ce_b),
      .ram_dout(ram_dout_b)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int seed = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] init_val(input int i);
      if (i == 32'h123) return 8'h5A;
      return 8'(i * 37 + seed) ^ 8'(i >> 2);
   endfunction

   // Reference memory image: initial contents plus every completed CPU write.
   logic [DW-1:0] ref_mem [1024];

   // Synchronous-read RAMs, one per arbiter.
   logic          mem_init_done = 1'b0;
   logic [DW-1:0] mem_a [1024];
   logic [DW-1:0] mem_b [1024];
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 1024; i++) begin
            mem_a[i] <= init_val(i);
            mem_b[i] <= init_val(i);
         end
         mem_init_done <= 1'b1;
      end else begin
         if (ram_ce_a) begin
            if (ram_we_a) mem_a[ram_a_a] <= ram_din_a;
            ram_dout_a <= mem_a[ram_a_a];
         end
         if (ram_ce_b) begin
            if (ram_we_b) mem_b[ram_a_b] <= ram_din_b;
            ram_dout_b <= mem_b[ram_a_b];
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Negedge monitor of arbiter A: video scoreboard and access counters.
   logic          vid_acked = 1'b0;
   logic          last_ack = 1'b0;
   int            we_count = 0, we_cyc = 0, ack_count = 0, stall_count = 0, cpu_ce_count = 0;
   logic [AW-1:0] vq_addr [$];
   int            vq_cyc [$];
   always @(negedge clk) begin
      logic [AW-1:0] a;
      int c;
      vid_acked = vid_ack_a;
      if (ram_we_a) begin
         we_count++;
         we_cyc = cyc;
      end
      if (ram_ce_a && !last_ack) cpu_ce_count++;
      last_ack = vid_ack_a;
      if (vid_req && !vid_ack_a) stall_count++;
      if (vid_ack_a) begin
         ack_count++;
         vq_addr.push_back(vid_addr);
         vq_cyc.push_back(cyc);
      end
      if (vid_valid_a) begin
         if (vq_addr.size() == 0) begin
            check("vid_spurious_valid", 32'd1, 32'd0);
         end else begin
            a = vq_addr.pop_front();
            c = vq_cyc.pop_front();
            check("vid_data", 32'(vid_data_a), 32'(ref_mem[a]));
            check("vid_latency", 32'(cyc - c), 32'd2);
         end
      end
   end

   // Video source: holds the address until acked by arbiter A, then advances.
   logic [AW-1:0] vid_addr_r = '0;
   int            vid_left = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      if (vid_acked && vid_left > 0) begin
         vid_addr_r = vid_addr_r + 1'b1;
         vid_left--;
      end
      vid_req  = (vid_left > 0);
      vid_addr = vid_addr_r;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && (vid_left > 0 || vq_addr.size() > 0); k++) tick();
      check("vid_drain", 32'(vq_addr.size()), 32'd0);
   endtask

   // One CPU bus cycle. exp_a is arbiter A's expected stall; arbiter B (no override)
   // is expected to stall base + every leading cycle that video was requesting.
   task automatic run_cpu(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din,
                          input int hold, input int exp_a, input string tag);
      int lat_a = 0, lat_b = 0, vid_hi = 0, start = 0, we0 = 0, ce0 = 0;
      bit done_a = 0, done_b = 0, vid_gone = 0;
      tick();
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
      start = cyc; we0 = we_count; ce0 = cpu_ce_count;
      for (int k = 0; k < 80 && !(done_a && done_b); k++) begin
         @(negedge clk);
         if (!vid_req) vid_gone = 1;
         if (!vid_gone) vid_hi++;
         if (cpu_wait_n_a) done_a = 1; else if (!done_a) lat_a++;
         if (cpu_wait_n_b) done_b = 1; else if (!done_b) lat_b++;
         if (!(done_a && done_b)) tick();
      end
      check({tag, "_lat_a"}, 32'(lat_a), 32'(exp_a));
      check({tag, "_lat_b"}, 32'(lat_b), 32'((we ? 2 : 3) + vid_hi));
      if (!we) begin
         check({tag, "_dout_a"}, 32'(cpu_dout_a), 32'(ref_mem[addr]));
         check({tag, "_dout_b"}, 32'(cpu_dout_b), 32'(ref_mem[addr]));
      end
      repeat (hold) tick();
      tick();
      cpu_req = 1'b0; cpu_we = 1'b0;
      tick();
      tick();
      check({tag, "_ram_we_pulses"}, 32'(we_count - we0), we ? 32'd1 : 32'd0);
      check({tag, "_cpu_accesses"}, 32'(cpu_ce_count - ce0), 32'd1);
      if (we) begin
         check({tag, "_we_cycle"}, 32'(we_cyc - start), 32'(exp_a - 1));
         ref_mem[addr] = din;
      end
      $display("cpu %s we=%0d addr=0x%03h din=0x%02h lat_a=%0d lat_b=%0d dout_a=0x%02h",
               tag, we, addr, din, lat_a, lat_b, cpu_dout_a);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ack0, stall0, ce0;
      logic [AW-1:0] ra;
      logic [DW-1:0] old;

      seed = int'($urandom_range(0, 255));
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

      // Reset held with both requesters active: outputs must sit at reset values.
      cpu_req = 1'b1; vid_req = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ram_we", 32'(ram_we_a), 32'd0);
      check("rst_ram_ce", 32'(ram_ce_a), 32'd0);
      check("rst_ram_a", 32'(ram_a_a), 32'd0);
      check("rst_ram_din", 32'(ram_din_a), 32'd0);
      check("rst_vid_ack", 32'(vid_ack_a), 32'd0);
      check("rst_vid_valid", 32'(vid_valid_a), 32'd0);
      check("rst_cpu_dout", 32'(cpu_dout_a), 32'd0);
      check("rst_wait_n", 32'(cpu_wait_n_a), 32'd1);
      $display("reset values checked");
      tick();
      cpu_req = 1'b0;
      rst_n = 1'b1;
      tick();

      run_cpu(1'b0, 10'h123, 8'h00, 0, 3, "read_alone");
      check("read_alone_5a", 32'(cpu_dout_a), 32'h5A);

      run_cpu(1'b1, 10'h3FF, 8'hA5, 10, 2, "write_hold");
      run_cpu(1'b0, 10'h3FF, 8'h00, 0, 3, "readback");
      check("readback_a5", 32'(cpu_dout_a), 32'hA5);

      // Video burst 0..7 with no CPU traffic.
      ack0 = ack_count; stall0 = stall_count;
      vid_addr_r = '0; vid_left = 8;
      drain();
      check("burst_acks", 32'(ack_count - ack0), 32'd8);
      check("burst_stalls", 32'(stall_count - stall0), 32'd0);
      $display("video burst acks=%0d", ack_count - ack0);

      // Contention: A overrides after 8 denials, B waits for video to stop.
      vid_addr_r = 10'd100; vid_left = 25;
      tick(); tick();
      stall0 = stall_count;
      ra = 10'($urandom);
      run_cpu(1'b0, ra, 8'h00, 0, 11, "starve_read");
      check("starve_vid_lost", 32'(stall_count - stall0), 32'd1);
      drain();

      // Abort while pending, then a fresh read must see a cleared counter.
      vid_addr_r = 10'd200; vid_left = 40;
      tick(); tick();
      ce0 = cpu_ce_count;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'($urandom);
      repeat (3) begin
         @(negedge clk);
         check("abort_pending_wait", 32'(cpu_wait_n_a), 32'd0);
         tick();
      end
      cpu_req = 1'b0;
      tick(); tick();
      check("abort_no_access", 32'(cpu_ce_count - ce0), 32'd0);
      check("abort_wait_n", 32'(cpu_wait_n_a), 32'd1);
      $display("abort done");
      run_cpu(1'b0, 10'($urandom), 8'h00, 0, 11, "after_abort");
      drain();

      // Random uncontended accesses.
      for (int i = 0; i < 8; i++) begin
         logic w;
         w = 1'($urandom_range(0, 1));
         run_cpu(w, 10'($urandom), 8'($urandom), int'($urandom_range(0, 3)), w ? 2 : 3, "rand");
      end

      // Reset during the write slot: the write must never reach the RAM.
      run_cpu(1'b0, 10'h123, 8'h00, 0, 3, "pre_rst_read");
      ra = 10'h2AA; old = ref_mem[ra];
      tick();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = ra; cpu_din = ~old;
      tick();
      @(negedge clk);
      check("mid_write_we", 32'(ram_we_a), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ram_we", 32'(ram_we_a), 32'd0);
      check("mid_rst_ram_ce", 32'(ram_ce_a), 32'd0);
      check("mid_rst_wait_n", 32'(cpu_wait_n_a), 32'd1);
      check("mid_rst_ram_a", 32'(ram_a_a), 32'd0);
      check("mid_rst_ram_din", 32'(ram_din_a), 32'd0);
      check("mid_rst_cpu_dout", 32'(cpu_dout_a), 32'd0);
      check("mid_rst_vid_valid", 32'(vid_valid_a), 32'd0);
      $display("reset mid-write checked");
      tick();
      cpu_req = 1'b0; cpu_we = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      run_cpu(1'b0, ra, 8'h00, 0, 3, "post_rst_read");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
